// File: rtl/mult_share_ctrl.sv
// Round-robin front end that shares one sequential 4x4 shift-add multiplier
// among NREQ requesters: grant, issue START, wait for READY (with timeout), reply.
module mult_share_ctrl #(
  parameter int NREQ = 4,
  parameter int TMO  = 15
) (
  input  logic              CK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic [4*NREQ-1:0] REQ_A,
  input  logic [4*NREQ-1:0] REQ_B,
  output logic [NREQ-1:0]   GNT,
  output logic [NREQ-1:0]   DONE,
  output logic [7:0]        RESULT,
  output logic              ERR,
  output logic              BUSY,
  output logic [3:0]        MA,
  output logic [3:0]        MB,
  output logic              MSTART,
  input  logic              MREADY,
  input  logic [7:0]        MP
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_ARM,
    S_WAIT,
    S_RESP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      ma_q, ma_d;
  logic [3:0]      mb_q, mb_d;
  logic [7:0]      result_q, result_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            mstart_q, mstart_d;
  logic [NREQ-1:0] done_q, done_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;

  function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int k);
    return IW'((int'(base) + k) % NREQ);
  endfunction

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_found && REQ[rr_index(ptr_q, k)]) begin
        win_found = 1'b1;
        win_idx   = rr_index(ptr_q, k);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned; that is what keeps this block free of inferred latches.
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    result_d = '0;
    err_d    = 1'b0;
    done_d   = '0;
    mstart_d = 1'b0;
    GNT      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          GNT[win_idx] = 1'b1;
          ma_d         = REQ_A[{win_idx, 2'b00} +: 4];
          mb_d         = REQ_B[{win_idx, 2'b00} +: 4];
          owner_d      = win_idx;
          ptr_d        = rr_index(win_idx, 1);
          mstart_d     = 1'b1;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_ARM;
      S_ARM: begin
        // READY may still show the previous product here, so it is not looked at.
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (MREADY) begin
          result_d        = MP;
          done_d[owner_q] = 1'b1;
          state_d         = S_RESP;
        end else if (cnt_q == CW'(TMO - 1)) begin
          err_d           = 1'b1;
          done_d[owner_q] = 1'b1;
          state_d         = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      mstart_q <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      result_q <= result_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      mstart_q <= mstart_d;
      done_q   <= done_d;
    end
  end

  assign DONE   = done_q;
  assign RESULT = result_q;
  assign ERR    = err_q;
  assign BUSY   = busy_q;
  assign MA     = ma_q;
  assign MB     = mb_q;
  assign MSTART = mstart_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Self-checking bench for mult_share_ctrl: transaction-level reference model
// plus a behavioural multiplier with programmable READY latency.
module tb_mult_share_ctrl;
  localparam int NREQ = 4;
  localparam int TMO  = 15;

  logic              CK;
  logic              RST;
  logic [NREQ-1:0]   REQ;
  logic [4*NREQ-1:0] REQ_A, REQ_B;
  logic [NREQ-1:0]   GNT, DONE;
  logic [7:0]        RESULT;
  logic              ERR, BUSY, MSTART;
  logic [3:0]        MA, MB;
  logic              MREADY;
  logic [7:0]        MP;

  mult_share_ctrl #(.NREQ(NREQ), .TMO(TMO)) dut (
    .CK(CK), .RST(RST), .REQ(REQ), .REQ_A(REQ_A), .REQ_B(REQ_B),
    .GNT(GNT), .DONE(DONE), .RESULT(RESULT), .ERR(ERR), .BUSY(BUSY),
    .MA(MA), .MB(MB), .MSTART(MSTART), .MREADY(MREADY), .MP(MP)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Multiplier stand-in: READY rises cur_lat cycles after START is sampled,
  // READY/P keep their stale values for the first cycle after START.
  logic [7:0] m_p     = '0;
  logic       m_ready = 1'b0;
  logic [3:0] m_a     = '0, m_b = '0;
  int         m_left  = 0;
  int         cur_lat = 5;
  bit         cur_stuck = 1'b0;

  always @(posedge CK) begin
    if (MSTART === 1'b1) begin
      m_a    <= MA;
      m_b    <= MB;
      m_left <= cur_stuck ? 0 : cur_lat;
      if (cur_stuck) m_ready <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_ready <= 1'b1;
        m_p     <= m_a * m_b;
      end else begin
        m_ready <= 1'b0;
        m_p     <= 8'($urandom);
      end
    end
  end
  assign MREADY = m_ready;
  assign MP     = m_p;

  // Requester side
  bit         pending [NREQ];
  logic [3:0] opa [NREQ];
  logic [3:0] opb [NREQ];
  bit         hold_all = 1'b0;
  int         next_lat = 5;
  bit         next_stuck = 1'b0;

  task automatic request(input int i, input logic [3:0] a, input logic [3:0] b);
    opa[i]     = a;
    opb[i]     = b;
    pending[i] = 1'b1;
  endtask

  initial begin
    RST   = 1'b1;
    REQ   = '0;
    REQ_A = '0;
    REQ_B = '0;
    for (int i = 0; i < NREQ; i++) begin
      pending[i] = 1'b0;
      opa[i]     = '0;
      opb[i]     = '0;
    end
    forever begin
      @(posedge CK);
      cyc++;
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hold_all && !pending[i]) begin
          opa[i]     = 4'($urandom);
          opb[i]     = 4'($urandom);
          pending[i] = 1'b1;
        end
        REQ[i]           = pending[i];
        REQ_A[4*i +: 4]  = opa[i];
        REQ_B[4*i +: 4]  = opb[i];
      end
    end
  end

  // Reference model: one operation at a time, timeline fixed at grant.
  bit         rst_seen = 1'b0;
  bit         m_active = 1'b0;
  int         m_tg, m_tr, m_owner;
  int         m_ptr = 0;
  logic [7:0] m_res;
  bit         m_err;
  logic [3:0] m_ma = '0, m_mb = '0;

  int         gnt_q[$], gnt_cyc_q[$];
  int         done_vec_q[$], done_res_q[$], done_err_q[$], done_cyc_q[$];

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i] === 1'b1) return i;
    return -1;
  endfunction

  initial begin
    logic [NREQ-1:0] e_gnt, e_done;
    logic [7:0]      e_res;
    logic            e_err, e_mst;
    int              w, idx;
    bit              tmo;
    forever begin
      @(negedge CK);
      if (rst_seen) begin
        e_gnt = '0; e_done = '0; e_res = '0; e_err = 1'b0; e_mst = 1'b0; w = -1;
        if (!m_active) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && REQ[idx]) w = idx;
          end
          if (w >= 0) e_gnt[w] = 1'b1;
        end else begin
          e_mst = (cyc == m_tg + 1);
          if (cyc == m_tr) begin
            e_done[m_owner] = 1'b1;
            e_res = m_res;
            e_err = m_err;
          end
        end
        check("gnt", GNT, e_gnt);
        check("done", DONE, e_done);
        check("result", RESULT, e_res);
        check("err", ERR, e_err);
        check("busy", BUSY, m_active);
        check("mstart", MSTART, e_mst);
        check("ma", MA, m_ma);
        check("mb", MB, m_mb);

        if (GNT != '0) begin
          gnt_q.push_back(onehot_idx(GNT));
          gnt_cyc_q.push_back(cyc);
        end
        if (DONE != '0) begin
          done_vec_q.push_back(int'(DONE));
          done_res_q.push_back(int'(RESULT));
          done_err_q.push_back(int'(ERR));
          done_cyc_q.push_back(cyc);
        end

        if (!RST && !m_active && w >= 0) begin
          m_active   = 1'b1;
          m_tg       = cyc;
          m_owner    = w;
          m_ma       = opa[w];
          m_mb       = opb[w];
          m_ptr      = (w + 1) % NREQ;
          pending[w] = 1'b0;
          cur_lat    = next_lat;
          cur_stuck  = next_stuck;
          tmo        = cur_stuck || (cur_lat > TMO);
          m_tr       = cyc + 3 + (tmo ? TMO : cur_lat);
          m_res      = tmo ? 8'd0 : 8'(opa[w] * opb[w]);
          m_err      = tmo;
        end else if (m_active && cyc == m_tr) begin
          m_active = 1'b0;
        end
      end
      if (RST) begin
        rst_seen = 1'b1;
        m_active = 1'b0;
        m_ptr    = 0;
        m_ma     = '0;
        m_mb     = '0;
      end
    end
  end

  function automatic bit any_pending();
    for (int i = 0; i < NREQ; i++) if (pending[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    bit ok = 1'b0;
    for (int n = 0; n < budget && !ok; n++) begin
      @(posedge CK);
      ok = !any_pending() && !m_active;
    end
    check(name, ok, 1);
    #2;
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    int target = gnt_q.size() + n;
    bit ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge CK);
      ok = (gnt_q.size() >= target);
    end
    check(name, ok, 1);
    #2;
  endtask

  // Single operation with hand-computed expectations.
  task automatic op_expect(input string name, input int i, input logic [3:0] a,
                           input logic [3:0] b, input int exp_res, input int exp_err,
                           input int exp_lat);
    int gb = gnt_q.size();
    int db = done_res_q.size();
    request(i, a, b);
    wait_idle({name, "_idle"}, 100);
    check({name, "_gnt"},  gnt_q[gb], i);
    check({name, "_done"}, done_vec_q[db], 1 << i);
    check({name, "_res"},  done_res_q[db], exp_res);
    check({name, "_err"},  done_err_q[db], exp_err);
    check({name, "_lat"},  done_cyc_q[db] - gnt_cyc_q[gb], exp_lat);
  endtask

  initial begin
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int gb, db, dcnt;

    repeat (2) @(posedge CK);
    #2 RST = 1'b0;
    @(negedge CK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_ma", MA, 0);
    @(posedge CK); #2;

    // Single op and operand extremes
    op_expect("single", 0, 4'd3, 4'd5, 15, 0, 8);
    op_expect("max", 1, 4'd15, 4'd15, 225, 0, 8);
    op_expect("zero", 2, 4'd0, 4'd9, 0, 0, 8);
    op_expect("r3", 3, 4'd7, 4'd7, 49, 0, 8);

    // Fairness with all requests held
    gb = gnt_q.size();
    hold_all = 1'b1;
    wait_grants("fair_grants", 5, 200);
    hold_all = 1'b0;
    wait_idle("fair_idle", 200);
    for (int k = 0; k < 5; k++) check("fair_order", gnt_q[gb + k], exp_order[k]);

    op_expect("ptr1", 0, 4'd2, 4'd2, 4, 0, 8);
    gb = gnt_q.size();
    request(0, 4'd1, 4'd3);
    request(2, 4'd2, 4'd3);
    wait_idle("rr0101_idle", 100);
    check("rr0101_first", gnt_q[gb], 2);
    check("rr0101_second", gnt_q[gb + 1], 0);

    // Contention while busy
    gb = gnt_q.size();
    db = done_res_q.size();
    request(0, 4'd5, 4'd6);
    wait_grants("cont_g0", 1, 50);
    repeat (3) @(posedge CK);
    #2 request(3, 4'd4, 4'd4);
    wait_idle("cont_idle", 100);
    check("cont_order", gnt_q[gb + 1], 3);
    check("cont_gap", gnt_cyc_q[gb + 1] - done_cyc_q[db], 1);
    check("cont_res0", done_res_q[db], 30);
    check("cont_res3", done_res_q[db + 1], 16);

    // Timeout and latency boundary
    next_stuck = 1'b1;
    op_expect("tmo_stuck", 1, 4'd9, 4'd9, 0, 1, 18);
    next_stuck = 1'b0;
    op_expect("after_tmo", 2, 4'd6, 4'd7, 42, 0, 8);
    next_lat = 15;
    op_expect("lat15", 3, 4'd3, 4'd3, 9, 0, 18);
    next_lat = 16;
    op_expect("lat16", 0, 4'd2, 4'd3, 0, 1, 18);
    next_lat = 1;
    op_expect("lat1", 1, 4'd12, 4'd11, 132, 0, 4);

    // Reset in WAIT
    next_lat = 10;
    dcnt = done_res_q.size();
    request(0, 4'd8, 4'd8);
    wait_grants("rst_mid_g", 1, 50);
    repeat (3) @(posedge CK);
    #2 RST = 1'b1;
    @(posedge CK);
    #2 RST = 1'b0;
    @(negedge CK);
    check("rst_mid_busy", BUSY, 0);
    check("rst_mid_ma", MA, 0);
    check("rst_mid_mstart", MSTART, 0);
    repeat (20) @(posedge CK);
    #2 check("rst_mid_nodone", done_res_q.size() - dcnt, 0);
    next_lat = 5;
    gb = gnt_q.size();
    db = done_res_q.size();
    request(0, 4'd7, 4'd9);
    request(2, 4'd1, 4'd1);
    wait_idle("rst_after_idle", 100);
    check("rst_after_ptr", gnt_q[gb], 0);
    check("rst_after_res", done_res_q[db], 63);

    // Randomized traffic
    gb = gnt_q.size();
    db = done_res_q.size();
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pending[i] && $urandom_range(0, 5) == 0)
          request(i, 4'($urandom), 4'($urandom));
      next_lat   = $urandom_range(1, 17);
      next_stuck = ($urandom_range(0, 19) == 0);
      @(posedge CK); #2;
    end
    wait_idle("rand_idle", 300);
    check("rand_count", done_res_q.size() - db, gnt_q.size() - gb);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
